// File: rtl/mdu_hilo_unit.sv
// rtl/mdu_hilo_unit.sv - multi-cycle multiply/divide unit with HI/LO; option MDU_FAST_MULT_EN
module mdu_hilo_unit #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ex_wr,
  input  logic        ex_dis_wr,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAX_N = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W = $clog2(MAX_N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // acc: partial remainder (divide) or upper product half (multiply)
  // sh : dividend shifting into quotient, or multiplier shifting into lower product half
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       sh_q, sh_d;
  logic [31:0]       opb_q, opb_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              is_div_q, is_div_d;
  logic [31:0]       res_hi_q, res_hi_d;
  logic [31:0]       res_lo_q, res_lo_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic              is_mul_op, is_div_op, is_signed_op, start, commit_ok;
  logic [31:0]       mag_a, mag_b;
  logic [CNT_W-1:0]  cnt_last;

  assign is_mul_op    = op_valid && (op == OP_MULT || op == OP_MULTU);
  assign is_div_op    = op_valid && (op == OP_DIV || op == OP_DIVU);
  assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign start        = (state_q == S_IDLE) && !flush && (is_mul_op || is_div_op);
  assign commit_ok    = ex_wr && !ex_dis_wr && !flush;
  assign mag_a        = (is_signed_op && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign mag_b        = (is_signed_op && src_b[31]) ? (~src_b + 32'd1) : src_b;
  assign cnt_last     = is_div_q ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

  assign hi = hi_q;
  assign lo = lo_q;

`ifdef MDU_FAST_MULT_EN
  logic [63:0] fast_mag, fast_prod;
  assign fast_mag  = {32'd0, mag_a} * {32'd0, mag_b};
  assign fast_prod = (is_signed_op && (src_a[31] ^ src_b[31])) ? (~fast_mag + 64'd1) : fast_mag;
`endif

  logic [32:0] rem_shift, rem_sub, mul_sum;
  logic        div_ge;
  logic [31:0] step_acc, step_sh;

  // one restoring-divide or shift-add-multiply iteration on the magnitudes
  always_comb begin
    rem_shift = {acc_q, sh_q[31]};
    rem_sub   = rem_shift - {1'b0, opb_q};
    div_ge    = rem_shift >= {1'b0, opb_q};
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : 33'd0);
    if (is_div_q) begin
      step_acc = div_ge ? rem_sub[31:0] : rem_shift[31:0];
      step_sh  = {sh_q[30:0], div_ge};
    end else begin
      step_acc = mul_sum[32:1];
      step_sh  = {mul_sum[0], sh_q[31:1]};
    end
  end

  logic        neg_res;
  logic [31:0] quot_fix, rem_fix, fin_hi, fin_lo;
  logic [63:0] prod_mag, prod_fix;

  // sign fix-up of the last iteration's output; with a zero divisor every step
  // subtracts nothing, so the remainder path ends holding |a| and rem_fix equals src_a
  always_comb begin
    neg_res  = sign_a_q ^ sign_b_q;
    quot_fix = neg_res ? (~step_sh + 32'd1) : step_sh;
    rem_fix  = sign_a_q ? (~step_acc + 32'd1) : step_acc;
    prod_mag = {step_acc, step_sh};
    prod_fix = neg_res ? (~prod_mag + 64'd1) : prod_mag;
    if (is_div_q) begin
      fin_hi = rem_fix;
      fin_lo = (opb_q == 32'd0) ? 32'hFFFF_FFFF : quot_fix;
    end else begin
      fin_hi = prod_fix[63:32];
      fin_lo = prod_fix[31:0];
    end
  end

  // next-state, datapath loads, HI/LO writes and the combinational busy
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opb_d    = opb_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy     = 1'b1;
          acc_d    = 32'd0;
          sh_d     = mag_a;
          opb_d    = mag_b;
          sign_a_d = is_signed_op && src_a[31];
          sign_b_d = is_signed_op && src_b[31];
          is_div_d = is_div_op;
          cnt_d    = '0;
          state_d  = S_RUN;
`ifdef MDU_FAST_MULT_EN
          if (is_mul_op) begin
            res_hi_d = fast_prod[63:32];
            res_lo_d = fast_prod[31:0];
            state_d  = S_DONE;
          end
`endif
        end else if (op_valid && commit_ok) begin
          if (op == OP_MTHI) hi_d = src_a;
          if (op == OP_MTLO) lo_d = src_a;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          busy  = 1'b1;
          acc_d = step_acc;
          sh_d  = step_sh;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == cnt_last) begin
            res_hi_d = fin_hi;
            res_lo_d = fin_lo;
            cnt_d    = '0;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (commit_ok) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= 32'd0;
      sh_q     <= 32'd0;
      opb_q    <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opb_q    <= opb_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// tb/tb_mdu_hilo_unit.sv - self-checking bench for mdu_hilo_unit
module tb_mdu_hilo_unit;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        ex_wr, ex_dis_wr, flush;
  logic        busy;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdu_hilo_unit dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .ex_wr(ex_wr), .ex_dis_wr(ex_dis_wr),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // architectural result of an MDU op as {hi, lo}
  function automatic logic [63:0] ref_result(input logic [2:0] f_op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f_op)
      3'd0: ref_result = 64'(sa * sb);
      3'd1: ref_result = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_result = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
        else ref_result = {a % b, a / b};
      end
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  int          m_left;
  bit          m_have;

  // model: an op is busy for its latency after the start cycle, then waits for a commit
  always @(posedge clk) begin
    if (!resetn) begin
      m_hi <= 0; m_lo <= 0; m_left <= 0; m_have <= 0;
    end else if (flush) begin
      m_left <= 0; m_have <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_have <= 1;
    end else if (m_have) begin
      if (ex_wr && !ex_dis_wr) begin
        m_hi <= m_res_hi; m_lo <= m_res_lo; m_have <= 0;
      end
    end else if (op_valid) begin
      if (op <= 3'd3) begin
        {m_res_hi, m_res_lo} <= ref_result(op, src_a, src_b);
        m_left <= (op >= 3'd2) ? DIV_LAT : MUL_LAT;
        m_have <= (op < 3'd2) && (MUL_LAT == 0);
      end else if (ex_wr && !ex_dis_wr) begin
        if (op == 3'd4) m_hi <= src_a;
        if (op == 3'd5) m_lo <= src_a;
      end
    end
  end

  // compare every cycle out of reset
  always @(negedge clk) begin
    logic eb;
    if (resetn) begin
      eb = flush ? 1'b0 : (m_left > 0) ? 1'b1 : m_have ? 1'b0 : (op_valid && op <= 3'd3);
      chk("busy_model", {31'd0, busy}, {31'd0, eb});
      chk("hi_model", hi, m_hi);
      chk("lo_model", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt);
    bit done;
    op_valid = 1; op = o; src_a = a; src_b = b;
    ex_wr = 0; ex_dis_wr = 0; flush = 0;
    busy_cnt = 0;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
      busy_cnt++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL busy_timeout: busy still high after 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic commit();
    ex_wr = 1; ex_dis_wr = 0;
    tick();
    op_valid = 0; ex_wr = 0;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    op_valid = 1; op = o; src_a = v; src_b = 0;
    ex_wr = 1; ex_dis_wr = 0; flush = 0;
    #2;
    chk("mt_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    op_valid = 0; ex_wr = 0;
  endtask

  initial begin
    int bc;
    resetn = 0; op_valid = 0; op = 0; src_a = 0; src_b = 0;
    ex_wr = 0; ex_dis_wr = 0; flush = 0;
    repeat (3) tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    resetn = 1;
    tick();

    start_op(3'd3, 32'd100, 32'd7, bc);
    chk("divu_busy_len", bc, 33);
    commit();
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    start_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc);
    chk("div_busy_len", bc, 33);
    commit();
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    commit();
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    start_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    chk("mult_busy_len", bc, MUL_LAT + 1);
    commit();
    chk("mult_hi", hi, 32'd0);
    chk("mult_lo", lo, 32'd1);

    start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    chk("multu_busy_len", bc, MUL_LAT + 1);
    commit();
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'd1);

    start_op(3'd0, 32'hFFFF_FFFD, 32'd7, bc);
    commit();
    chk("mult_mixed_hi", hi, 32'hFFFF_FFFF);
    chk("mult_mixed_lo", lo, 32'hFFFF_FFEB);

    start_op(3'd3, 32'h0000_1234, 32'd0, bc);
    chk("divu0_busy_len", bc, 33);
    commit();
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'h0000_1234);

    start_op(3'd2, 32'hFFFF_FFF0, 32'd0, bc);
    commit();
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'hFFFF_FFF0);

    mt(3'd4, 32'h0000_AAAA);
    mt(3'd5, 32'h0000_5555);
    chk("mthi_hi", hi, 32'h0000_AAAA);
    chk("mtlo_lo", lo, 32'h0000_5555);

    // flush in RUN cycle 10
    op_valid = 1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3; ex_wr = 0;
    repeat (11) tick();
    chk("run_busy_before_flush", {31'd0, busy}, 32'd1);
    flush = 1;
    #2;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    tick();
    flush = 0; op_valid = 0;
    #2;
    chk("after_flush_busy", {31'd0, busy}, 32'd0);
    ex_wr = 1;
    repeat (3) tick();
    ex_wr = 0;
    chk("flush_hi", hi, 32'h0000_AAAA);
    chk("flush_lo", lo, 32'h0000_5555);

    // flush on the start cycle prevents the start
    op_valid = 1; op = 3'd2; src_a = 32'd9; src_b = 32'd2; flush = 1;
    #2;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    tick();
    flush = 0; op_valid = 0;
    tick();

    // DONE held by stall, then write-disabled, then a single commit
    start_op(3'd3, 32'd50, 32'd5, bc);
    repeat (5) tick();
    ex_wr = 1; ex_dis_wr = 1;
    tick();
    chk("dis_busy", {31'd0, busy}, 32'd0);
    chk("dis_hi", hi, 32'h0000_AAAA);
    chk("dis_lo", lo, 32'h0000_5555);
    ex_dis_wr = 0;
    tick();
    op_valid = 0; ex_wr = 0;
    chk("late_commit_lo", lo, 32'd10);
    chk("late_commit_hi", hi, 32'd0);
    repeat (3) tick();

    mt(3'd5, 32'h0000_DEAD);
    chk("mtlo_dead", lo, 32'h0000_DEAD);

    // op 6 is a no-op
    op_valid = 1; op = 3'd6; src_a = 32'h999; ex_wr = 1;
    #2;
    chk("op6_busy", {31'd0, busy}, 32'd0);
    tick();
    op_valid = 0; ex_wr = 0;
    chk("op6_lo", lo, 32'h0000_DEAD);
    chk("op6_hi", hi, 32'd0);

    // asynchronous reset in the middle of a divide
    op_valid = 1; op = 3'd3; src_a = 32'd77; src_b = 32'd5; ex_wr = 0;
    repeat (4) tick();
    resetn = 0; op_valid = 0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    repeat (2) tick();
    resetn = 1;
    repeat (3) tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_hi", hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
